// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment, extension and misalign detect.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int COUNT_W = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               InValid,
  input  logic               RegWriteIn,
  input  logic               MemToRegIn,
  input  logic [1:0]         ByteSelIn,
  input  logic               SignExtIn,
  input  logic [31:0]        ALUResultIn,
  input  logic [31:0]        ReadDataIn,
  input  logic [4:0]         WriteRegIn,
  output logic               ValidOut,
  output logic               RegWriteOut,
  output logic [4:0]         WriteRegOut,
  output logic [31:0]        WriteBackData,
  output logic               MisalignOut
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [COUNT_W-1:0] RetireCount
`endif
);

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_BYTE = 2'b01;
  localparam logic [1:0] SEL_HALF = 2'b10;

  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wbdata_q, wbdata_d;
  logic        misalign_q, misalign_d;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        load_misalign;
  logic [31:0] cap_data;
  logic        cap_misalign;
  logic        cap_regwrite;
  logic        capture_en;

  always_comb begin
    byte_lane = ReadDataIn[7:0];
    case (ALUResultIn[1:0])
      2'd0:    byte_lane = ReadDataIn[7:0];
      2'd1:    byte_lane = ReadDataIn[15:8];
      2'd2:    byte_lane = ReadDataIn[23:16];
      default: byte_lane = ReadDataIn[31:24];
    endcase
    half_lane = ALUResultIn[1] ? ReadDataIn[31:16] : ReadDataIn[15:0];
  end

  // ByteSel 11 falls into the word path for both data and alignment.
  always_comb begin
    load_data     = ReadDataIn;
    load_misalign = (ALUResultIn[1:0] != 2'b00);
    case (ByteSelIn)
      SEL_BYTE: begin
        load_data     = {{24{SignExtIn & byte_lane[7]}}, byte_lane};
        load_misalign = 1'b0;
      end
      SEL_HALF: begin
        load_data     = {{16{SignExtIn & half_lane[15]}}, half_lane};
        load_misalign = ALUResultIn[0];
      end
      default: begin
        load_data     = ReadDataIn;
        load_misalign = (ALUResultIn[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    cap_data     = MemToRegIn ? load_data : ALUResultIn;
    cap_misalign = MemToRegIn & load_misalign;
    cap_regwrite = RegWriteIn & InValid & (WriteRegIn != 5'd0) & ~cap_misalign;
  end

  assign capture_en = ~Flush & ~Stall;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wreg_d     = wreg_q;
    wbdata_d   = wbdata_q;
    misalign_d = misalign_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      wreg_d     = 5'd0;
      wbdata_d   = 32'd0;
      misalign_d = 1'b0;
    end else if (!Stall) begin
      valid_d    = InValid;
      regwrite_d = cap_regwrite;
      wreg_d     = WriteRegIn;
      wbdata_d   = cap_data;
      misalign_d = cap_misalign;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wbdata_q   <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wbdata_q   <= wbdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign ValidOut      = valid_q;
  assign RegWriteOut   = regwrite_q;
  assign WriteRegOut   = wreg_q;
  assign WriteBackData = wbdata_q;
  assign MisalignOut   = misalign_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [COUNT_W-1:0] retire_q, retire_d;

  // Natural binary wrap at 2^COUNT_W.
  always_comb begin
    retire_d = retire_q;
    if (capture_en && InValid) retire_d = retire_q + COUNT_W'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign RetireCount = retire_q;
`else
  logic unused_capture_en;
  assign unused_capture_en = capture_en;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0, rw_in = 1'b0, m2r = 1'b0, sext = 1'b0;
  logic [1:0]  bsel = 2'b00;
  logic [31:0] alu = 32'd0, rdata = 32'd0;
  logic [4:0]  wreg = 5'd0;
  logic        valid_o, rw_o, mis_o;
  logic [4:0]  wreg_o;
  logic [31:0] wb_o;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CW-1:0] cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic        e_valid, e_rw, e_mis;
  logic [4:0]  e_wreg;
  logic [31:0] e_wb;
  int unsigned e_cnt;

  mem_wb_stage #(.COUNT_W(CW)) dut (
    .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush), .InValid(in_valid),
    .RegWriteIn(rw_in), .MemToRegIn(m2r), .ByteSelIn(bsel), .SignExtIn(sext),
    .ALUResultIn(alu), .ReadDataIn(rdata), .WriteRegIn(wreg),
    .ValidOut(valid_o), .RegWriteOut(rw_o), .WriteRegOut(wreg_o),
    .WriteBackData(wb_o), .MisalignOut(mis_o)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .RetireCount(cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_rw = 0; e_mis = 0; e_wreg = 0; e_wb = 0; e_cnt = 0;
  endtask

  // Expected write-back value and misalignment from the access rules, using shifts and masks.
  task automatic model_edge();
    int unsigned lane, v;
    logic mis;
    if (flush) begin
      e_valid = 0; e_rw = 0; e_mis = 0; e_wreg = 0; e_wb = 0;
      return;
    end
    if (stall) return;
    lane = alu % 4;
    mis  = 0;
    if (bsel == 2'b01) begin
      v = (rdata >> (8 * lane)) & 32'hFF;
      if (sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (bsel == 2'b10) begin
      v = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
      if (sext && v >= 32768) v = v + 32'hFFFF_0000;
      mis = (alu % 2) != 0;
    end else begin
      v   = rdata;
      mis = lane != 0;
    end
    if (!m2r) begin
      v = alu;
      mis = 0;
    end
    e_valid = in_valid;
    e_mis   = mis;
    e_wreg  = wreg;
    e_wb    = v;
    e_rw    = rw_in && in_valid && wreg != 0 && !mis;
    if (in_valid) e_cnt = (e_cnt + 1) % (1 << CW);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e_valid});
    check({tag, ".regwr"}, {31'd0, rw_o},    {31'd0, e_rw});
    check({tag, ".wreg"},  {27'd0, wreg_o},  {27'd0, e_wreg});
    check({tag, ".wbdata"}, wb_o, e_wb);
    check({tag, ".misal"}, {31'd0, mis_o},   {31'd0, e_mis});
`ifdef MEM_WB_RETIRE_CNT_EN
    check({tag, ".retire"}, {{(32-CW){1'b0}}, cnt_o}, e_cnt);
`endif
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [1:0] bs,
                       input logic se, input logic [31:0] a, input logic [31:0] rd,
                       input logic [4:0] wr, input logic st, input logic fl);
    @(negedge clk);
    in_valid = v; rw_in = rw; m2r = mr; bsel = bs; sext = se;
    alu = a; rdata = rd; wreg = wr; stall = st; flush = fl;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    drive(1, 1, 1, 2'b01, 1, 32'h1003, 32'h80FF_1234, 5'd7, 0, 0);
    step("sbyte");
    check("sbyte.val", wb_o, 32'hFFFF_FF80);
    check("sbyte.rw", {31'd0, rw_o}, 32'd1);

    drive(1, 1, 1, 2'b10, 0, 32'h2002, 32'hBEEF_0001, 5'd8, 0, 0);
    step("uhalf");
    check("uhalf.val", wb_o, 32'h0000_BEEF);

    drive(1, 1, 1, 2'b00, 0, 32'h3001, 32'h1111_2222, 5'd5, 0, 0);
    step("mword");
    check("mword.mis", {31'd0, mis_o}, 32'd1);
    check("mword.rw", {31'd0, rw_o}, 32'd0);
    check("mword.valid", {31'd0, valid_o}, 32'd1);

    drive(1, 1, 0, 2'b00, 0, 32'h55, 32'hDEAD_BEEF, 5'd3, 0, 0);
    step("hold55");
    drive(1, 1, 0, 2'b00, 0, 32'h99, 32'h0, 5'd4, 1, 0);
    step("stall");
    check("stall.held", wb_o, 32'h55);
    drive(1, 1, 0, 2'b00, 0, 32'h77, 32'h0, 5'd6, 1, 1);
    step("stflush");
    check("stflush.wb", wb_o, 32'h0);
    check("stflush.valid", {31'd0, valid_o}, 32'd0);

    drive(1, 1, 0, 2'b01, 1, 32'h1234, 32'hFFFF_FFFF, 5'd0, 0, 0);
    step("zdst");
    check("zdst.rw", {31'd0, rw_o}, 32'd0);
    check("zdst.wb", wb_o, 32'h1234);

    drive(1, 1, 0, 2'b00, 0, 32'hABCD, 32'h0, 5'd9, 0, 0);
    step("prestall");
    drive(1, 1, 0, 2'b00, 0, 32'h1, 32'h0, 5'd1, 1, 0);
    step("stall2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("asyncrst");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1, 2'b10, 1, 32'h0006, 32'h8001_7FFF, 5'd2, 0, 0);
    step("postrst");
    check("postrst.wb", wb_o, 32'hFFFF_8001);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31:5], 5'd0};
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            2'($urandom_range(0, 3)), $urandom_range(0, 1), a, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      step("rand");
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 2'b00, 0, 32'(i), 32'h0, 5'd1, 0, 0);
      step("cnt");
    end
    check("cnt.wrap", {{(32-CW){1'b0}}, cnt_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("cnt.rst", {{(32-CW){1'b0}}, cnt_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
